status_stack_register: RTL and testbench
========================================

STATUS_STACK_REGISTER -- requirements
Module: status_stack_register

Interface
REQ-001 SHALL provide parameter FLAG_W, default 4, number of status flag bits (range 1..16).
REQ-002 SHALL provide parameter STACK_DEPTH, default 4, number of save/restore stack entries (range 1..16).
REQ-003 SHALL provide parameter DW = $clog2(STACK_DEPTH+1), derived, width of the depth counter.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n_in  input  1  reset, asynchronous assert, active-low.
REQ-006 status_in  input  FLAG_W  new flag values.
REQ-007 status_mask_in  input  FLAG_W  per-bit write enable for status_in.
REQ-008 status_write_en_in  input  1  masked flag write strobe.
REQ-009 cond_sel_in  input  FLAG_W  flags tested by the condition.
REQ-010 cond_mode_in  input  2  00 ANY, 01 NONE, 10 ALL, 11 NOT_ALL.
REQ-011 cond_eval_en_in  input  1  condition evaluation strobe.
REQ-012 push_in  input  1  save current flags to stack.
REQ-013 pop_in  input  1  restore flags from stack.
REQ-014 err_clr_in  input  1  clear sticky error.
REQ-015 status_out  output  FLAG_W  current flag register.
REQ-016 cond_out  output  1  registered condition result.
REQ-017 depth_out  output  DW  occupied stack entries.
REQ-018 full_out / empty_out  output  1 each  depth_out==STACK_DEPTH / depth_out==0, combinational from depth.
REQ-019 stack_err_out  output  1  sticky overflow/underflow/conflict flag.

Function
REQ-020 Masked write: when status_write_en_in=1 and no pop, flag[i] SHALL take status_in[i] where status_mask_in[i]=1, else keep its value; visible on status_out next cycle.
REQ-021 Condition: when cond_eval_en_in=1, cond_out SHALL load next cycle: ANY=|(F&S), NONE=~|(F&S), ALL=&(F|~S), NOT_ALL=~&(F|~S), F=flag register value before this edge, S=cond_sel_in.
REQ-022 With S=0: ANY=0, NONE=1, ALL=1, NOT_ALL=0.
REQ-023 cond_out SHALL hold its value while cond_eval_en_in=0.
REQ-024 Push (push_in=1, pop_in=0, not full): pre-edge flag value stored at entry depth_out; depth_out increments by 1.
REQ-025 Pop (pop_in=1, push_in=0, not empty): flag register loads entry depth_out-1; depth_out decrements by 1; a simultaneous write is discarded.
REQ-026 Push with simultaneous write: stack stores the pre-write flags; flag register takes the masked write.
REQ-027 Push when full: no stack or depth change, stack_err_out set; a simultaneous write still applies.
REQ-028 Pop when empty: flags and depth unchanged, stack_err_out set; a simultaneous write still applies.
REQ-029 push_in=1 and pop_in=1 together: no stack, depth or pop-restore change, stack_err_out set; a simultaneous write applies.
REQ-030 stack_err_out SHALL stay set until err_clr_in=1; an error in the same cycle as err_clr_in SHALL win (stays 1).
REQ-031 Condition evaluation in a push/pop/write cycle SHALL use pre-edge flags (REQ-021).
REQ-032 Stack storage contents are not reset; only entries below depth_out are observable via pop.

Reset
REQ-033 reset_n_in=0 SHALL immediately force status_out=0, cond_out=0, depth_out=0, stack_err_out=0 (empty_out=1, full_out=0), regardless of clock.
REQ-034 Reset asserted mid-push/pop SHALL discard the operation; first edge after deassertion behaves as normal from reset state.

Verification
REQ-035 Reset, write status_in=1010 mask=1111, then mask=0011 status_in=0101 -> status_out 1010, then 1001.
REQ-036 Flags=1001: eval S=1000 each mode -> ANY 1, NONE 0; S=1001 ALL 1; S=1011 ALL 0, NOT_ALL 1; S=0000 ALL 1, ANY 0.
REQ-037 FLAG_W=4, DEPTH=4: push 0001,0010,0100,1000 (writing between) -> full_out=1; 5th push -> err=1, depth 4; pop x4 -> status_out 1000,0100,0010,0001; 5th pop -> status_out 0001, empty_out=1.
REQ-038 Flags=0011, push+write 1100 same cycle -> status_out 1100; pop -> 0011; push+pop together -> depth unchanged, err=1; err_clr -> err=0.
REQ-039 Async reset pulse between clock edges with depth 2, flags 1111 -> outputs zero immediately, before next edge.

Source files
------------

// File: rtl/status_stack_register.sv
// Status flag register with masked writes, condition evaluation and a
// save/restore stack of flag snapshots with a sticky misuse error.
module status_stack_register #(
    parameter int unsigned FLAG_W      = 4,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic [FLAG_W-1:0] status_in,
    input  logic [FLAG_W-1:0] status_mask_in,
    input  logic              status_write_en_in,
    input  logic [FLAG_W-1:0] cond_sel_in,
    input  logic [1:0]        cond_mode_in,
    input  logic              cond_eval_en_in,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic              err_clr_in,
    output logic [FLAG_W-1:0] status_out,
    output logic              cond_out,
    output logic [DW-1:0]     depth_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              stack_err_out
);

    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] MODE_ANY     = 2'b00;
    localparam logic [1:0] MODE_NONE    = 2'b01;
    localparam logic [1:0] MODE_ALL     = 2'b10;
    localparam logic [1:0] MODE_NOT_ALL = 2'b11;

    logic [FLAG_W-1:0] stack_mem [STACK_DEPTH];
    logic              push_ok;
    logic              pop_ok;
    logic              err_evt;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [FLAG_W-1:0] wr_flags;
    logic [FLAG_W-1:0] flags_nxt;
    logic              any_hit;
    logic              all_hit;
    logic              cond_c;

    assign full_out  = (depth_out == DW'(STACK_DEPTH));
    assign empty_out = (depth_out == '0);

    // Stack control, flag next-value and condition result
    always_comb begin
        push_ok   = push_in & ~pop_in & ~full_out;
        pop_ok    = pop_in & ~push_in & ~empty_out;
        err_evt   = (push_in & pop_in) | (push_in & full_out) | (pop_in & empty_out);
        wr_idx    = AW'(depth_out);
        rd_idx    = AW'(depth_out - DW'(1));
        wr_flags  = status_out;
        if (status_write_en_in) begin
            wr_flags = (status_out & ~status_mask_in) | (status_in & status_mask_in);
        end
        // a successful pop restores the snapshot and drops any concurrent write
        flags_nxt = pop_ok ? stack_mem[rd_idx] : wr_flags;
        any_hit   = |(status_out & cond_sel_in);
        all_hit   = &(status_out | ~cond_sel_in);
        cond_c    = 1'b0;
        case (cond_mode_in)
            MODE_ANY:     cond_c = any_hit;
            MODE_NONE:    cond_c = ~any_hit;
            MODE_ALL:     cond_c = all_hit;
            MODE_NOT_ALL: cond_c = ~all_hit;
            default:      cond_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            status_out    <= '0;
            cond_out      <= 1'b0;
            depth_out     <= '0;
            stack_err_out <= 1'b0;
        end else begin
            status_out <= flags_nxt;
            if (cond_eval_en_in) begin
                cond_out <= cond_c;
            end
            if (push_ok) begin
                depth_out <= depth_out + DW'(1);
            end else if (pop_ok) begin
                depth_out <= depth_out - DW'(1);
            end
            // a new error wins over a same-cycle clear
            if (err_evt) begin
                stack_err_out <= 1'b1;
            end else if (err_clr_in) begin
                stack_err_out <= 1'b0;
            end
        end
    end

    // Snapshot storage is not reset; only entries below depth_out are observable
    always_ff @(posedge clk_in) begin
        if (push_ok && reset_n_in) begin
            stack_mem[wr_idx] <= status_out;
        end
    end

endmodule

// File: tb/tb_status_stack_register.sv
// Self-checking bench for status_stack_register: queue-based reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_status_stack_register;

    localparam int unsigned FW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic          clk_in = 1'b0;
    logic          reset_n_in;
    logic [FW-1:0] status_in, status_mask_in, cond_sel_in;
    logic          status_write_en_in, cond_eval_en_in, push_in, pop_in, err_clr_in;
    logic [1:0]    cond_mode_in;
    logic [FW-1:0] status_out;
    logic          cond_out, full_out, empty_out, stack_err_out;
    logic [DW-1:0] depth_out;

    status_stack_register #(.FLAG_W(FW), .STACK_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .status_in(status_in), .status_mask_in(status_mask_in),
        .status_write_en_in(status_write_en_in),
        .cond_sel_in(cond_sel_in), .cond_mode_in(cond_mode_in),
        .cond_eval_en_in(cond_eval_en_in),
        .push_in(push_in), .pop_in(pop_in), .err_clr_in(err_clr_in),
        .status_out(status_out), .cond_out(cond_out), .depth_out(depth_out),
        .full_out(full_out), .empty_out(empty_out), .stack_err_out(stack_err_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [FW-1:0] m_flags;
    logic          m_cond;
    logic          m_err;
    logic [FW-1:0] m_stack [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_cond  = 1'b0;
        m_err   = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_update();
        logic [FW-1:0] pre;
        logic [FW-1:0] wr;
        logic [FW-1:0] hits;
        bit            any, all, bad;
        if (!reset_n_in) begin
            model_reset();
            return;
        end
        pre  = m_flags;
        wr   = status_write_en_in ? ((pre & ~status_mask_in) | (status_in & status_mask_in)) : pre;
        hits = pre & cond_sel_in;
        any  = (hits != '0);
        all  = (hits == cond_sel_in);
        if (cond_eval_en_in) begin
            case (cond_mode_in)
                2'd0: m_cond = any;
                2'd1: m_cond = !any;
                2'd2: m_cond = all;
                default: m_cond = !all;
            endcase
        end
        bad     = 1'b0;
        m_flags = wr;
        if (push_in && pop_in) begin
            bad = 1'b1;
        end else if (push_in) begin
            if (m_stack.size() == DEPTH) bad = 1'b1;
            else m_stack.push_back(pre);
        end else if (pop_in) begin
            if (m_stack.size() == 0) bad = 1'b1;
            else m_flags = m_stack.pop_back();
        end
        if (bad) m_err = 1'b1;
        else if (err_clr_in) m_err = 1'b0;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("status", 32'(status_out), 32'(m_flags));
            check("cond", 32'(cond_out), 32'(m_cond));
            check("depth", 32'(depth_out), 32'(m_stack.size()));
            check("full", 32'(full_out), 32'(m_stack.size() == DEPTH));
            check("empty", 32'(empty_out), 32'(m_stack.size() == 0));
            check("err", 32'(stack_err_out), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        model_update();
        #1;
        status_write_en_in = 1'b0;
        cond_eval_en_in    = 1'b0;
        push_in            = 1'b0;
        pop_in             = 1'b0;
        err_clr_in         = 1'b0;
    endtask

    task automatic wr(input logic [FW-1:0] v, input logic [FW-1:0] m);
        status_in          = v;
        status_mask_in     = m;
        status_write_en_in = 1'b1;
    endtask

    task automatic eval(input logic [FW-1:0] s, input logic [1:0] mode, input logic exp, input string name);
        cond_sel_in     = s;
        cond_mode_in    = mode;
        cond_eval_en_in = 1'b1;
        tick();
        check(name, 32'(cond_out), 32'(exp));
    endtask

    initial begin
        reset_n_in = 1'b0;
        status_in = '0; status_mask_in = '0; cond_sel_in = '0; cond_mode_in = '0;
        status_write_en_in = 0; cond_eval_en_in = 0; push_in = 0; pop_in = 0; err_clr_in = 0;
        model_reset();
        #12;
        check("rst_status", 32'(status_out), 32'h0);
        check("rst_empty", 32'(empty_out), 32'h1);
        check("rst_full", 32'(full_out), 32'h0);
        reset_n_in = 1'b1;
        cmp_en     = 1'b1;

        // Masked writes
        wr(4'b1010, 4'b1111); tick();
        check("wr_full_mask", 32'(status_out), 32'b1010);
        wr(4'b0101, 4'b0011); tick();
        check("wr_part_mask", 32'(status_out), 32'b1001);

        // Condition modes with flags 1001
        eval(4'b1000, 2'd0, 1'b1, "cond_any");
        eval(4'b1000, 2'd1, 1'b0, "cond_none");
        eval(4'b1001, 2'd2, 1'b1, "cond_all");
        eval(4'b1011, 2'd2, 1'b0, "cond_all_miss");
        eval(4'b1011, 2'd3, 1'b1, "cond_not_all");
        eval(4'b0000, 2'd2, 1'b1, "cond_all_s0");
        eval(4'b0000, 2'd0, 1'b0, "cond_any_s0");
        cond_sel_in = 4'b1000; tick();
        check("cond_hold", 32'(cond_out), 32'h0);

        // Fill the stack, overflow, drain, underflow
        for (int i = 0; i < 4; i++) begin
            wr(4'(1 << i), 4'b1111); tick();
            push_in = 1'b1; tick();
        end
        check("fill_full", 32'(full_out), 32'h1);
        push_in = 1'b1; wr(4'b0001, 4'b0001); tick();
        check("ovf_err", 32'(stack_err_out), 32'h1);
        check("ovf_depth", 32'(depth_out), 32'h4);
        check("ovf_write", 32'(status_out), 32'b1001);
        err_clr_in = 1'b1; tick();
        check("err_clr", 32'(stack_err_out), 32'h0);
        for (int i = 3; i >= 0; i--) begin
            pop_in = 1'b1; tick();
            check($sformatf("pop%0d", i), 32'(status_out), 32'(1 << i));
        end
        pop_in = 1'b1; tick();
        check("unf_status", 32'(status_out), 32'b0001);
        check("unf_empty", 32'(empty_out), 32'h1);
        check("unf_err", 32'(stack_err_out), 32'h1);
        err_clr_in = 1'b1; tick();

        // Push with write, pop discarding write, push+pop conflict
        wr(4'b0011, 4'b1111); tick();
        push_in = 1'b1; wr(4'b1100, 4'b1111); tick();
        check("push_wr", 32'(status_out), 32'b1100);
        pop_in = 1'b1; wr(4'b1111, 4'b1111); tick();
        check("pop_restore", 32'(status_out), 32'b0011);
        push_in = 1'b1; pop_in = 1'b1; tick();
        check("pp_depth", 32'(depth_out), 32'h0);
        check("pp_err", 32'(stack_err_out), 32'h1);
        err_clr_in = 1'b1; tick();
        check("pp_clr", 32'(stack_err_out), 32'h0);
        push_in = 1'b1; pop_in = 1'b1; err_clr_in = 1'b1; tick();
        check("err_wins", 32'(stack_err_out), 32'h1);
        err_clr_in = 1'b1; tick();

        // Mixed stimulus against the model
        for (int i = 0; i < 80; i++) begin
            status_in = 4'($urandom); status_mask_in = 4'($urandom);
            status_write_en_in = 1'($urandom);
            cond_sel_in = 4'($urandom); cond_mode_in = 2'($urandom);
            cond_eval_en_in = 1'($urandom);
            push_in = ($urandom_range(0, 2) == 0);
            pop_in  = ($urandom_range(0, 2) == 0);
            err_clr_in = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Async reset between edges with depth 2, flags 1111
        err_clr_in = 1'b1; tick();
        while (depth_out != '0) begin pop_in = 1'b1; tick(); end
        wr(4'b1111, 4'b1111); tick();
        push_in = 1'b1; tick();
        push_in = 1'b1; eval(4'b1111, 2'd2, 1'b1, "pre_rst_cond");
        check("pre_rst_depth", 32'(depth_out), 32'h2);
        #2;
        reset_n_in = 1'b0;
        model_reset();
        #1;
        check("arst_status", 32'(status_out), 32'h0);
        check("arst_cond", 32'(cond_out), 32'h0);
        check("arst_depth", 32'(depth_out), 32'h0);
        check("arst_empty", 32'(empty_out), 32'h1);
        check("arst_err", 32'(stack_err_out), 32'h0);

        // Push held across an edge in reset is discarded
        push_in = 1'b1; wr(4'b0110, 4'b1111);
        @(posedge clk_in); model_update();
        #2;
        check("rst_push_depth", 32'(depth_out), 32'h0);
        reset_n_in = 1'b1;
        status_write_en_in = 1'b0;
        tick();
        check("post_rst_depth", 32'(depth_out), 32'h1);
        pop_in = 1'b1; tick();
        check("post_rst_pop", 32'(status_out), 32'h0);
        tick();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
